vedic3_seq_mult: RTL

VEDIC3_SEQ_MULT -- requirements
Module: vedic3_seq_mult

---
 rtl/vedic3_seq_mult.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/vedic3_seq_mult.sv
// vedic3_seq_mult: sequential unsigned multiplier that computes a W x W product
// (W = 3*NDIG) from NDIG*NDIG digit-by-digit partial products. Each partial
// product comes from one shared 3x3 vedic core, one product per cycle.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (a_in, b_in unsigned, W bits)
//   abort                synchronous cancel of the operation in progress
//   out_valid/out_ready  result handshake (product_out unsigned, 2W bits)
//   busy                 operation in progress or result waiting

// 3x3 vedic (vertical and crosswise) multiplier core.
module vedic3x3_core (
  input  logic [2:0] a,
  input  logic [2:0] b,
  output logic [5:0] p
);
  logic [5:0] c0, c1, c2, c3, c4;

  // Column sums of the crosswise digit products, weighted by column position.
  assign c0 = 6'(a[0] & b[0]);
  assign c1 = 6'(a[1] & b[0]) + 6'(a[0] & b[1]);
  assign c2 = 6'(a[2] & b[0]) + 6'(a[1] & b[1]) + 6'(a[0] & b[2]);
  assign c3 = 6'(a[2] & b[1]) + 6'(a[1] & b[2]);
  assign c4 = 6'(a[2] & b[2]);

  assign p = c0 + (c1 << 1) + (c2 << 2) + (c3 << 3) + (c4 << 4);
endmodule

module vedic3_seq_mult #(
  parameter int NDIG = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3*NDIG-1:0]   a_in,
  input  logic [3*NDIG-1:0]   b_in,
  input  logic                abort,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [6*NDIG-1:0]   product_out,
  output logic                busy
);
  localparam int W  = 3 * NDIG;
  localparam int PW = 2 * W;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [IW-1:0]   i_idx;
  logic [IW-1:0]   j_idx;
  logic            issue_en;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic [2:0]      a_dig;
  logic [2:0]      b_dig;
  logic [5:0]      core_p;
  logic [PW-1:0]   pp_shift;
  logic [PW-1:0]   pp_p1;
  logic            vld_p1;
  logic            last_p1;
  logic [PW-1:0]   acc;
  logic            accept;
  logic            last_step;
  logic            j_wrap;

  assign accept    = (state == IDLE) && in_valid && !abort;
  assign j_wrap    = (j_idx == IW'(NDIG - 1));
  assign last_step = j_wrap && (i_idx == IW'(NDIG - 1));

  assign a_dig = a_reg[3*i_idx +: 3];
  assign b_dig = b_reg[3*j_idx +: 3];

  vedic3x3_core u_core (
    .a (a_dig),
    .b (b_dig),
    .p (core_p)
  );

  // Partial product weighted by its digit position 3*(i+j), full 2W width.
  assign pp_shift = PW'(core_p) << (3 * (int'(i_idx) + int'(j_idx)));

  // Stage p0 -> p1: operand capture and registered partial product.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_reg <= a_in;
      b_reg <= b_in;
    end
    if (state == RUN && issue_en) begin
      pp_p1 <= pp_shift;
    end
  end

  // Control and accumulator (stage p1 -> result).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      i_idx    <= '0;
      j_idx    <= '0;
      issue_en <= 1'b0;
      vld_p1   <= 1'b0;
      last_p1  <= 1'b0;
      acc      <= '0;
    end else begin
      case (state)
        IDLE: begin
          vld_p1  <= 1'b0;
          last_p1 <= 1'b0;
          if (accept) begin
            state    <= RUN;
            acc      <= '0;
            i_idx    <= '0;
            j_idx    <= '0;
            issue_en <= 1'b1;
          end
        end
        RUN: begin
          if (abort) begin
            state    <= IDLE;
            acc      <= '0;
            i_idx    <= '0;
            j_idx    <= '0;
            issue_en <= 1'b0;
            vld_p1   <= 1'b0;
            last_p1  <= 1'b0;
          end else begin
            vld_p1  <= issue_en;
            last_p1 <= issue_en && last_step;
            // j inner, i outer; issuing stops after the final digit pair.
            if (issue_en) begin
              if (j_wrap) begin
                j_idx <= '0;
                if (last_step) begin
                  i_idx    <= '0;
                  issue_en <= 1'b0;
                end else begin
                  i_idx <= i_idx + 1'b1;
                end
              end else begin
                j_idx <= j_idx + 1'b1;
              end
            end
            if (vld_p1) begin
              acc <= acc + pp_p1;
              if (last_p1) state <= DONE;
            end
          end
        end
        DONE: begin
          // abort wins over a pending handshake: the result is dropped.
          if (abort) begin
            state <= IDLE;
            acc   <= '0;
          end else if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign busy        = (state == RUN) || (state == DONE);
  assign product_out = acc;
endmodule
